// File: rtl/burst_mem_ctrl.sv
// burst_mem_ctrl: services one read or write burst at a time against an internal word array.
// Read beats come from a registered data stage; write bursts end on the beat count and finish with a one-cycle response.
module burst_mem_ctrl #(
   parameter int DATA_WIDTH      = 32,
   parameter int DATA_ADDR_WIDTH = 32,
   parameter int NUM_WORDS       = 128,
   parameter int READ_BURST_LEN  = 8,
   parameter int WRITE_BURST_LEN = 8
) (
   input  logic                       sys_clk,
   input  logic                       sys_rst,
   input  logic                       req_valid,
   output logic                       req_ready,
   input  logic                       req_write,
   input  logic [DATA_ADDR_WIDTH-1:0] req_addr,
   input  logic                       wdata_valid,
   output logic                       wdata_ready,
   input  logic [DATA_WIDTH-1:0]      wdata,
   input  logic                       wdata_last,
   output logic                       rdata_valid,
   input  logic                       rdata_ready,
   output logic [DATA_WIDTH-1:0]      rdata,
   output logic                       rdata_last,
   output logic                       wresp_valid,
   output logic                       wresp_err
);
   localparam int IDX_W   = $clog2(NUM_WORDS);
   localparam int MAX_LEN = (READ_BURST_LEN > WRITE_BURST_LEN) ? READ_BURST_LEN : WRITE_BURST_LEN;
   localparam int CNT_W   = $clog2(MAX_LEN + 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RD    = 2'd1,
      S_WR    = 2'd2,
      S_WRESP = 2'd3
   } state_t;

   state_t                state_q, state_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  err_q, err_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  rdata_last_q, rdata_last_d;
   logic [IDX_W-1:0]      req_idx;
   logic                  rd_final;
   logic                  wr_final;
   logic                  unused_addr;
   logic [DATA_WIDTH-1:0] mem [NUM_WORDS];

   // Byte offset and bits above the array depth are don't-care.
   assign req_idx     = req_addr[IDX_W+1:2];
   assign unused_addr = ^req_addr;
   assign rd_final    = (cnt_q == CNT_W'(READ_BURST_LEN - 1));
   assign wr_final    = (cnt_q == CNT_W'(WRITE_BURST_LEN - 1));

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q      <= S_IDLE;
         idx_q        <= '0;
         cnt_q        <= '0;
         err_q        <= 1'b0;
         rdata_q      <= '0;
         rdata_last_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         cnt_q        <= cnt_d;
         err_q        <= err_d;
         rdata_q      <= rdata_d;
         rdata_last_q <= rdata_last_d;
      end
   end

   // Array is deliberately outside reset so contents survive a reset.
   always_ff @(posedge sys_clk) begin
      if (state_q == S_WR && wdata_valid) begin
         mem[idx_q] <= wdata;
      end
   end

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      cnt_d        = cnt_q;
      err_d        = err_q;
      rdata_d      = rdata_q;
      rdata_last_d = rdata_last_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               idx_d = req_idx;
               cnt_d = '0;
               err_d = 1'b0;
               if (req_write) begin
                  state_d = S_WR;
               end else begin
                  state_d      = S_RD;
                  rdata_d      = mem[req_idx];
                  rdata_last_d = (READ_BURST_LEN == 1);
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RD: begin
            if (rdata_ready) begin
               idx_d = idx_q + IDX_W'(1);
               cnt_d = cnt_q + CNT_W'(1);
               if (rd_final) begin
                  state_d      = S_IDLE;
                  rdata_last_d = 1'b0;
               end else begin
                  rdata_d      = mem[idx_q + IDX_W'(1)];
                  rdata_last_d = (cnt_q + CNT_W'(1) == CNT_W'(READ_BURST_LEN - 1));
               end
            end else begin
               state_d = S_RD;
            end
         end
         S_WR: begin
            if (wdata_valid) begin
               idx_d = idx_q + IDX_W'(1);
               cnt_d = cnt_q + CNT_W'(1);
               err_d = err_q | (wdata_last != wr_final);
               if (wr_final) begin
                  state_d = S_WRESP;
               end else begin
                  state_d = S_WR;
               end
            end else begin
               state_d = S_WR;
            end
         end
         S_WRESP: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      req_ready   = 1'b0;
      wdata_ready = 1'b0;
      rdata_valid = 1'b0;
      wresp_valid = 1'b0;
      wresp_err   = 1'b0;
      rdata       = rdata_q;
      rdata_last  = rdata_last_q;
      case (state_q)
         S_IDLE:  req_ready   = 1'b1;
         S_RD:    rdata_valid = 1'b1;
         S_WR:    wdata_ready = 1'b1;
         S_WRESP: begin
            wresp_valid = 1'b1;
            wresp_err   = err_q;
         end
         default: req_ready = 1'b0;
      endcase
   end
endmodule
